// File: rtl/serial_parity_receiver.sv
// serial_parity_receiver: deserializes DATA_W data bits (LSB first) plus one
// trailing parity bit, checks parity with a running XOR and presents the word.
// Latency: out_valid pulses in the cycle after the parity bit is accepted.
// Backpressure: none; every bit presented with in_valid=1 is accepted.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - in_bit is meaningful this cycle
//   in_bit     - serial data / parity bit
//   clear      - synchronous frame abort (wins over in_valid)
//   out_valid  - one-cycle pulse, frame complete
//   out_data   - received word, bit 0 = first received bit (held between frames)
//   parity_err - parity mismatch for the word on out_data (held between frames)
//   busy       - a frame is partially received
module serial_parity_receiver #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              clear,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              parity_err,
  output logic              busy
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic            ODD_BIT  = (ODD != 0);

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_PAR  = 1'b1
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_acc;
  logic [DATA_W-1:0]   r_shift;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_parity_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_DATA;
      r_cnt        <= '0;
      r_acc        <= 1'b0;
      r_shift      <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_parity_err <= 1'b0;
    end else begin
      // Strobe defaults low; only the parity-accept branch raises it.
      r_out_valid <= 1'b0;
      if (clear) begin
        // Abort the frame but keep the last completed word visible.
        r_state <= ST_DATA;
        r_cnt   <= '0;
        r_acc   <= 1'b0;
      end else if (in_valid) begin
        case (r_state)
          ST_DATA: begin
            // Every bit position is rewritten each frame, so no clear is needed.
            r_shift[r_cnt] <= in_bit;
            r_acc          <= r_acc ^ in_bit;
            if (r_cnt == LAST_CNT) begin
              r_cnt   <= '0;
              r_state <= ST_PAR;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_PAR: begin
            r_out_data   <= r_shift;
            r_parity_err <= r_acc ^ in_bit ^ ODD_BIT;
            r_out_valid  <= 1'b1;
            r_acc        <= 1'b0;
            r_state      <= ST_DATA;
          end
          default: begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign parity_err = r_parity_err;
  assign busy       = (r_state == ST_PAR) || (r_cnt != '0);

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Directed bench for serial_parity_receiver: one even-parity and one odd-parity
// instance. Inputs change on the falling edge; outputs are sampled on the
// falling edge, half a cycle after the rising edge that updated them.
module tb_serial_parity_receiver;

  logic       clk;
  logic       rst;

  logic       e_in_valid, e_in_bit, e_clear;
  logic       e_out_valid, e_parity_err, e_busy;
  logic [7:0] e_out_data;

  logic       o_in_valid, o_in_bit, o_clear;
  logic       o_out_valid, o_parity_err, o_busy;
  logic [7:0] o_out_data;

  int n_checks;
  int n_errors;
  int e_pulses;
  int o_pulses;

  serial_parity_receiver #(.DATA_W(8), .ODD(0)) u_even (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (e_in_valid),
    .in_bit     (e_in_bit),
    .clear      (e_clear),
    .out_valid  (e_out_valid),
    .out_data   (e_out_data),
    .parity_err (e_parity_err),
    .busy       (e_busy)
  );

  serial_parity_receiver #(.DATA_W(8), .ODD(1)) u_odd (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (o_in_valid),
    .in_bit     (o_in_bit),
    .clear      (o_clear),
    .out_valid  (o_out_valid),
    .out_data   (o_out_data),
    .parity_err (o_parity_err),
    .busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and count any valid strobes seen there.
  task automatic tick();
    @(negedge clk);
    if (e_out_valid) e_pulses++;
    if (o_out_valid) o_pulses++;
  endtask

  task automatic gap(input int n);
    e_in_valid = 1'b0;
    o_in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input bit to_odd, input logic b);
    if (to_odd) begin
      o_in_valid = 1'b1;
      o_in_bit   = b;
    end else begin
      e_in_valid = 1'b1;
      e_in_bit   = b;
    end
    tick();
    e_in_valid = 1'b0;
    o_in_valid = 1'b0;
  endtask

  task automatic send_data(input bit to_odd, input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(to_odd, d[i]);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    e_pulses   = 0;
    o_pulses   = 0;
    e_in_valid = 1'b0; e_in_bit = 1'b0; e_clear = 1'b0;
    o_in_valid = 1'b0; o_in_bit = 1'b0; o_clear = 1'b0;
    rst        = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    gap(2);

    // Reset state
    check("rst_valid",   {31'b0, e_out_valid},  32'd0);
    check("rst_data",    {24'b0, e_out_data},   32'd0);
    check("rst_perr",    {31'b0, e_parity_err}, 32'd0);
    check("rst_busy",    {31'b0, e_busy},       32'd0);
    check("rst_odd_all", {28'b0, o_out_valid, o_parity_err, o_busy, |o_out_data}, 32'd0);

    // 0xA5, parity 0, in_valid held high
    e_pulses = 0;
    send_bit(0, 1'b1);
    check("a5_busy_bit0", {31'b0, e_busy}, 32'd1);
    send_bit(0, 1'b0); send_bit(0, 1'b1); send_bit(0, 1'b0);
    send_bit(0, 1'b0); send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b1);
    check("a5_novalid_pre_par", {31'b0, e_out_valid}, 32'd0);
    check("a5_busy_par",        {31'b0, e_busy},      32'd1);
    send_bit(0, 1'b0);
    check("a5_valid", {31'b0, e_out_valid},  32'd1);
    check("a5_data",  {24'b0, e_out_data},   32'h A5);
    check("a5_perr",  {31'b0, e_parity_err}, 32'd0);
    check("a5_busy_done", {31'b0, e_busy},   32'd0);
    gap(1);
    check("a5_valid_drop", {31'b0, e_out_valid}, 32'd0);
    check("a5_one_pulse",  e_pulses, 32'd1);

    // 0xA5 with bad parity, then 0x3C back-to-back
    e_pulses = 0;
    send_data(0, 8'hA5);
    send_bit(0, 1'b1);
    check("a5b_valid", {31'b0, e_out_valid},  32'd1);
    check("a5b_data",  {24'b0, e_out_data},   32'h A5);
    check("a5b_perr",  {31'b0, e_parity_err}, 32'd1);
    send_bit(0, 1'b0);  // first bit of 0x3C, presented while out_valid is high
    check("b2b_hold_data", {24'b0, e_out_data}, 32'h A5);
    check("b2b_busy",      {31'b0, e_busy},     32'd1);
    send_bit(0, 1'b0); send_bit(0, 1'b1); send_bit(0, 1'b1);
    send_bit(0, 1'b1); send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    check("3c_data", {24'b0, e_out_data},   32'h 3C);
    check("3c_perr", {31'b0, e_parity_err}, 32'd0);
    gap(1);
    check("3c_two_pulses", e_pulses, 32'd2);

    // 0x81 with 3-cycle gaps after bits 0, 4 and 7
    e_pulses = 0;
    send_bit(0, 1'b1);
    gap(3);
    check("gap0_busy", {31'b0, e_busy}, 32'd1);
    send_bit(0, 1'b0); send_bit(0, 1'b0); send_bit(0, 1'b0); send_bit(0, 1'b0);
    gap(3);
    send_bit(0, 1'b0); send_bit(0, 1'b0); send_bit(0, 1'b1);
    gap(3);
    check("gap7_busy",     {31'b0, e_busy},     32'd1);
    check("gap_no_pulse",  e_pulses,            32'd0);
    check("gap_hold_data", {24'b0, e_out_data}, 32'h 3C);
    send_bit(0, 1'b0);
    gap(1);
    check("81_pulses", e_pulses,              32'd1);
    check("81_data",   {24'b0, e_out_data},   32'h 81);
    check("81_perr",   {31'b0, e_parity_err}, 32'd0);

    // Partial frame of ones, clear together with an accepted-looking bit
    e_pulses = 0;
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
    e_clear    = 1'b1;
    e_in_valid = 1'b1;
    e_in_bit   = 1'b1;
    tick();
    e_clear    = 1'b0;
    e_in_valid = 1'b0;
    check("clr_busy",      {31'b0, e_busy},       32'd0);
    check("clr_hold_data", {24'b0, e_out_data},   32'h 81);
    check("clr_no_valid",  {31'b0, e_out_valid},  32'd0);
    send_data(0, 8'h0F);
    send_bit(0, 1'b0);
    gap(1);
    check("clr_pulses", e_pulses,              32'd1);
    check("clr_data",   {24'b0, e_out_data},   32'h 0F);
    check("clr_perr",   {31'b0, e_parity_err}, 32'd0);

    // Partial frame of ones, asynchronous reset mid-frame
    e_pulses = 0;
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    check("arst_data", {24'b0, e_out_data}, 32'd0);
    check("arst_busy", {31'b0, e_busy},     32'd0);
    send_data(0, 8'h0F);
    check("arst_data_pending", {24'b0, e_out_data}, 32'd0);
    send_bit(0, 1'b0);
    gap(1);
    check("arst_pulses", e_pulses,              32'd1);
    check("arst_data_f", {24'b0, e_out_data},   32'h 0F);
    check("arst_perr",   {31'b0, e_parity_err}, 32'd0);

    // Odd-parity instance
    o_pulses = 0;
    send_data(1, 8'h01);
    send_bit(1, 1'b0);
    check("odd_01_p0_valid", {31'b0, o_out_valid},  32'd1);
    check("odd_01_p0_data",  {24'b0, o_out_data},   32'h 01);
    check("odd_01_p0_perr",  {31'b0, o_parity_err}, 32'd0);
    send_data(1, 8'h01);
    send_bit(1, 1'b1);
    check("odd_01_p1_perr",  {31'b0, o_parity_err}, 32'd1);
    send_data(1, 8'h00);
    send_bit(1, 1'b1);
    check("odd_00_p1_data",  {24'b0, o_out_data},   32'h 00);
    check("odd_00_p1_perr",  {31'b0, o_parity_err}, 32'd0);
    gap(1);
    check("odd_pulses",      o_pulses,              32'd3);
    check("even_idle_odd",   e_pulses,              32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
